// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes and coin acceptor state encoding.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package vend_pkg;

   // Coin codes driven toward the vending FSM.
   typedef logic [1:0] coin_code_t;

   localparam coin_code_t COIN_NONE = 2'b00;
   localparam coin_code_t COIN_5    = 2'b01;
   localparam coin_code_t COIN_10   = 2'b10;

   // Coin acceptor control states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MEASURE = 3'd1,
      ST_EMIT    = 3'd2,
      ST_JAM     = 3'd3,
      ST_LOCKOUT = 3'd4
   } acc_state_t;

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor-in / coin-code-out bundle between the coin sensor, acceptor and vending FSM.
// Latency: none (wiring only).
// Backpressure: none; the consumer must take a coin code in the cycle it is shown.
interface coin_acceptor_if;

   logic                 coin_sense;
   vend_pkg::coin_code_t coin_code;
   logic                 coin_reject;
   logic                 busy;

   // Acceptor side.
   modport slave  (input coin_sense, output coin_code, output coin_reject, output busy);
   // Sensor driver / code consumer side.
   modport master (output coin_sense, input coin_code, input coin_reject, input busy);

endinterface

// File: rtl/coin_sync.sv
// Two-flop synchronizer for the asynchronous coin sensor line.
// Latency: 2 clk cycles from input change to o_sync.
// Backpressure: none.
module coin_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // Shift the raw line through two flops; both clear on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/coin_acceptor.sv
// Measures synchronized sensor pulse widths and classifies them into coin codes / rejects.
// Latency: code or reject 1 cycle after the synchronized line goes low (3 after raw fall).
// Backpressure: none; each result is a single-cycle pulse, followed by a lockout window.
module coin_acceptor
   import vend_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int GLITCH_MAX  = 3,
   parameter int W5_MIN      = 10,
   parameter int W5_MAX      = 20,
   parameter int W10_MIN     = 30,
   parameter int W10_MAX     = 45,
   parameter int LOCKOUT_CYC = 16
) (
   input  logic            clk,
   input  logic            rst,
   coin_acceptor_if.slave  bus
);

   localparam int LK_W = $clog2(LOCKOUT_CYC + 1);

   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_PRE_MAX = CNT_W'((2 ** CNT_W) - 2);
   localparam logic [CNT_W-1:0] C_GLITCH  = CNT_W'(GLITCH_MAX);
   localparam logic [CNT_W-1:0] C_W5_MIN  = CNT_W'(W5_MIN);
   localparam logic [CNT_W-1:0] C_W5_MAX  = CNT_W'(W5_MAX);
   localparam logic [CNT_W-1:0] C_W10_MIN = CNT_W'(W10_MIN);
   localparam logic [CNT_W-1:0] C_W10_MAX = CNT_W'(W10_MAX);
   // Last lockout count value; the exit decision is taken on that cycle.
   localparam logic [LK_W-1:0]  LK_LAST   = LK_W'(LOCKOUT_CYC - 1);

   logic             w_s;
   logic             w_glitch;
   logic             w_is5;
   logic             w_is10;

   acc_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [LK_W-1:0]  r_lock;
   coin_code_t       r_code;
   logic             r_rej;

   coin_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (bus.coin_sense),
      .o_sync  (w_s)
   );

   // Width classification of the completed pulse held in r_cnt.
   always_comb begin
      w_glitch = (r_cnt <= C_GLITCH);
      w_is5    = (r_cnt >= C_W5_MIN)  && (r_cnt <= C_W5_MAX);
      w_is10   = (r_cnt >= C_W10_MIN) && (r_cnt <= C_W10_MAX);
   end

   // Control FSM with registered single-cycle code/reject outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_LOCKOUT;
         r_cnt   <= '0;
         r_lock  <= '0;
         r_code  <= COIN_NONE;
         r_rej   <= 1'b0;
      end else begin
         r_code <= COIN_NONE;
         r_rej  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_s) begin
                  r_cnt   <= C_ONE;
                  r_state <= ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               if (w_s) begin
                  // Stepping onto the saturation value declares a jam; the counter never wraps.
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == C_PRE_MAX) begin
                     r_rej   <= 1'b1;
                     r_state <= ST_JAM;
                  end
               end else if (w_glitch) begin
                  r_state <= ST_IDLE;
               end else begin
                  // The result is registered straight into the outputs, shown during EMIT.
                  r_state <= ST_EMIT;
                  if (w_is5) begin
                     r_code <= COIN_5;
                  end else if (w_is10) begin
                     r_code <= COIN_10;
                  end else begin
                     r_rej <= 1'b1;
                  end
               end
            end
            ST_EMIT: begin
               r_lock  <= '0;
               r_state <= ST_LOCKOUT;
            end
            ST_JAM: begin
               if (!w_s) begin
                  r_lock  <= '0;
                  r_state <= ST_LOCKOUT;
               end
            end
            ST_LOCKOUT: begin
               // Dead time; a pulse still high at the end keeps us here until it drops.
               if (r_lock >= LK_LAST) begin
                  if (!w_s) begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_lock <= r_lock + 1'b1;
               end
            end
            default: begin
               r_state <= ST_LOCKOUT;
            end
         endcase
      end
   end

   assign bus.coin_code   = r_code;
   assign bus.coin_reject = r_rej;
   assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: vector table, corner sequences, random widths.
// Latency: n/a.
// Backpressure: n/a.
module tb_coin_acceptor;

   localparam int GLITCH_MAX  = 3;
   localparam int W5_MIN      = 10;
   localparam int W5_MAX      = 20;
   localparam int W10_MIN     = 30;
   localparam int W10_MAX     = 45;
   localparam int LOCKOUT_CYC = 16;
   localparam int OUT_LAT     = 3;
   localparam int TAIL        = 25;

   logic clk;
   logic rst;

   coin_acceptor_if bus_if ();

   coin_acceptor #(
      .CNT_W       (8),
      .GLITCH_MAX  (GLITCH_MAX),
      .W5_MIN      (W5_MIN),
      .W5_MAX      (W5_MAX),
      .W10_MIN     (W10_MIN),
      .W10_MAX     (W10_MAX),
      .LOCKOUT_CYC (LOCKOUT_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         width;
      logic [1:0] code;
      int         rej;
   } vec_t;

   vec_t vecs [13];

   int n_tests = 0;
   int n_fail  = 0;

   // Observation state, relative to the most recent raw falling edge (k = 0).
   int         k;
   int         code_cnt;
   int         rej_cnt;
   int         code_k;
   int         rej_k;
   int         last_busy_k;
   int         both_cnt = 0;
   logic [1:0] code_val;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_obs();
      code_cnt    = 0;
      rej_cnt     = 0;
      code_k      = -9999;
      rej_k       = -9999;
      last_busy_k = -9999;
      code_val    = 2'b00;
   endtask

   // Advance to the next falling clock edge and record the outputs.
   task automatic tick();
      @(negedge clk);
      k++;
      if (bus_if.coin_code != 2'b00) begin
         code_cnt++;
         code_val = bus_if.coin_code;
         code_k   = k;
      end
      if (bus_if.coin_reject) begin
         rej_cnt++;
         rej_k = k;
      end
      if (bus_if.coin_reject && (bus_if.coin_code != 2'b00)) both_cnt++;
      if (bus_if.busy) last_busy_k = k;
   endtask

   // Hold the raw sensor high for 'width' cycles, then drop it (k becomes 0 at the fall).
   task automatic pulse(input int width);
      k = -width;
      bus_if.coin_sense = 1'b1;
      repeat (width) tick();
      bus_if.coin_sense = 1'b0;
   endtask

   // Reference classification from the width windows.
   function automatic void classify(input int w, output logic [1:0] code, output int rej);
      code = 2'b00;
      rej  = 0;
      if (w <= GLITCH_MAX) begin
         code = 2'b00;
      end else if (w >= W5_MIN && w <= W5_MAX) begin
         code = 2'b01;
      end else if (w >= W10_MIN && w <= W10_MAX) begin
         code = 2'b10;
      end else begin
         rej = 1;
      end
   endfunction

   task automatic run_vector(input string name, input int w, input logic [1:0] ecode,
                             input int erej, input bit chk_busy_len);
      clear_obs();
      pulse(w);
      repeat (TAIL) tick();
      check({name, "_code_cnt"}, code_cnt, (ecode != 2'b00) ? 1 : 0);
      check({name, "_code_val"}, int'(code_val), int'(ecode));
      check({name, "_rej_cnt"}, rej_cnt, erej);
      if (ecode != 2'b00) check({name, "_code_lat"}, code_k, OUT_LAT);
      if (erej != 0)      check({name, "_rej_lat"}, rej_k, OUT_LAT);
      check({name, "_idle_after"}, int'(bus_if.busy), 0);
      if (chk_busy_len) begin
         if (ecode == 2'b00 && erej == 0)
            check({name, "_glitch_quick_idle"}, int'(last_busy_k <= OUT_LAT), 1);
         else
            check({name, "_lockout_len"}, int'(last_busy_k >= OUT_LAT + LOCKOUT_CYC), 1);
      end
   endtask

   initial begin
      logic [1:0] mcode;
      int         mrej;
      int         w;

      vecs[0]  = '{15, 2'b01, 0};
      vecs[1]  = '{40, 2'b10, 0};
      vecs[2]  = '{10, 2'b01, 0};
      vecs[3]  = '{20, 2'b01, 0};
      vecs[4]  = '{30, 2'b10, 0};
      vecs[5]  = '{45, 2'b10, 0};
      vecs[6]  = '{9,  2'b00, 1};
      vecs[7]  = '{21, 2'b00, 1};
      vecs[8]  = '{29, 2'b00, 1};
      vecs[9]  = '{46, 2'b00, 1};
      vecs[10] = '{1,  2'b00, 0};
      vecs[11] = '{3,  2'b00, 0};
      vecs[12] = '{4,  2'b00, 1};

      // Reset hold with the sensor already high.
      rst = 1'b1;
      bus_if.coin_sense = 1'b1;
      k = 0;
      clear_obs();
      repeat (3) tick();
      check("rst_busy", int'(bus_if.busy), 1);
      check("rst_code", int'(bus_if.coin_code), 0);
      check("rst_reject", int'(bus_if.coin_reject), 0);
      rst = 1'b0;
      repeat (30) tick();
      check("rst_release_busy", int'(bus_if.busy), 1);
      bus_if.coin_sense = 1'b0;
      repeat (20) tick();
      check("rst_then_idle", int'(bus_if.busy), 0);
      check("rst_no_code", code_cnt, 0);
      check("rst_no_reject", rej_cnt, 0);

      // Table of widths: valid coins, window edges, glitches.
      for (int i = 0; i < 13; i++) begin
         run_vector($sformatf("vec_w%0d", vecs[i].width), vecs[i].width,
                    vecs[i].code, vecs[i].rej, 1'b1);
      end

      // Jam: sensor stuck high well past counter saturation.
      clear_obs();
      pulse(300);
      repeat (40) tick();
      check("jam_rej_cnt", rej_cnt, 1);
      check("jam_code_cnt", code_cnt, 0);
      check("jam_rej_while_held", int'(rej_k < 0), 1);
      check("jam_idle_after", int'(bus_if.busy), 0);

      // Lockout: a pulse starting shortly after a coin is ignored, a later one is accepted.
      clear_obs();
      pulse(15);
      repeat (8) tick();
      check("lock_first_code", int'(code_val), 1);
      clear_obs();
      pulse(15);
      repeat (30) tick();
      check("lock_second_code_cnt", code_cnt, 0);
      check("lock_second_rej_cnt", rej_cnt, 0);
      run_vector("lock_third", 15, 2'b01, 0, 1'b0);

      // Reset just before the result would appear: the pulse is dropped.
      clear_obs();
      pulse(15);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (30) tick();
      check("midrst_code_cnt", code_cnt, 0);
      check("midrst_rej_cnt", rej_cnt, 0);
      check("midrst_idle", int'(bus_if.busy), 0);

      // Random widths with quiet gaps long enough to clear the lockout.
      for (int r = 0; r < 40; r++) begin
         w = int'($urandom_range(1, 60));
         classify(w, mcode, mrej);
         run_vector($sformatf("rnd%0d_w%0d", r, w), w, mcode, mrej, 1'b0);
      end

      check("never_code_and_reject", both_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
